// File: rtl/uart_rx_oversampled.sv
// UART receiver driven by a 16x oversample strobe: start/data/stop bits are
// sampled at mid-bit and a completed frame is presented on dout.
module uart_rx_oversampled #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            CLK_100MHZ,
  input  logic            reset,
  input  logic            tick,
  input  logic            rx,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_error
);

  localparam int              NW     = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [NW-1:0]   N_LAST = NW'(DBIT - 1);
  localparam logic [3:0]      S_STOP = 4'(SB_TICK - 1);
  localparam logic [3:0]      S_MID  = 4'd7;
  localparam logic [3:0]      S_BIT  = 4'd15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          state_r;
  logic [3:0]      s_r;
  logic [NW-1:0]   n_r;
  logic [DBIT-1:0] b_r;
  logic [DBIT-1:0] dout_r;
  logic            done_r;
  logic            ferr_r;
  logic [1:0]      sync_r;
  logic            rx_s;

  assign rx_s         = sync_r[1];
  assign dout         = dout_r;
  assign rx_done_tick = done_r;
  assign frame_error  = ferr_r;

  // Two-flop synchronizer for the asynchronous line; resets to the idle level.
  always_ff @(posedge CLK_100MHZ) begin
    if (reset) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], rx};
    end
  end

  // Receive FSM with registered data and one-cycle status pulses.
  always_ff @(posedge CLK_100MHZ) begin
    if (reset) begin
      state_r <= IDLE;
      s_r     <= 4'd0;
      n_r     <= '0;
      b_r     <= '0;
      dout_r  <= '0;
      done_r  <= 1'b0;
      ferr_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      ferr_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (rx_s == 1'b0) begin
            state_r <= START;
            s_r     <= 4'd0;
          end
        end
        START: begin
          if (tick) begin
            if (s_r == S_MID) begin
              s_r <= 4'd0;
              if (rx_s == 1'b0) begin
                state_r <= DATA;
                n_r     <= '0;
              end else begin
                // Start bit did not hold to mid-bit: treat it as a glitch.
                state_r <= IDLE;
              end
            end else begin
              s_r <= s_r + 4'd1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (s_r == S_BIT) begin
              s_r <= 4'd0;
              b_r <= {rx_s, b_r[DBIT-1:1]};
              if (n_r == N_LAST) begin
                state_r <= STOP;
              end else begin
                n_r <= n_r + {{(NW-1){1'b0}}, 1'b1};
              end
            end else begin
              s_r <= s_r + 4'd1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (s_r == S_STOP) begin
              state_r <= IDLE;
              s_r     <= 4'd0;
              if (rx_s == 1'b1) begin
                dout_r <= b_r;
                done_r <= 1'b1;
              end else begin
                ferr_r <= 1'b1;
              end
            end else begin
              s_r <= s_r + 4'd1;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          s_r     <= 4'd0;
        end
      endcase
    end
  end

endmodule
